// File: rtl/fetch_unit_pkg.sv
// Shared widths, constants and the fetch queue entry type for the instruction-fetch front end.
package fetch_unit_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode channel carrying {pc, instr} pairs.
// Handshake: a transfer completes on a rising edge where out_valid and out_ready are both 1;
// out_valid/out_instr/out_pc stay stable until that edge, and out_valid never depends on out_ready.
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic               out_valid;
  logic [INSTR_W-1:0] out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               out_ready;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);

endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush empties it and overrides a same-cycle push.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  input  fetch_entry_t                data_i,
  output fetch_entry_t                data_o,
  output logic [$clog2(QDEPTH):0]     count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(QDEPTH);

  fetch_entry_t  mem_q [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // A push into a full queue is only legal when the head leaves on the same edge.
  assign do_push = push_i && !flush_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Empty queue presents zeros so no stale entry is ever visible downstream.
  assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, fetch/redirect/error control and the fetch queue.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [XLEN-1:0]    imem_a,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  fetch_unit_if.master       dec,
  output logic               fetch_err
);

  logic [XLEN-1:0]         pc_q, pc_d;
  logic                    fetch_err_q, fetch_err_d;
  logic                    pop, push, q_full, q_empty;
  logic [$clog2(QDEPTH):0] q_count;
  fetch_entry_t            q_wdata, q_head;

  assign imem_a    = pc_q;
  assign fetch_err = fetch_err_q;

  assign pop     = dec.out_valid && dec.out_ready;
  assign push    = !redirect_valid && !fetch_err_q && (!q_full || pop);
  assign q_wdata = '{pc: pc_q, instr: imem_rd};

  always_comb begin
    pc_d        = pc_q;
    fetch_err_d = fetch_err_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      fetch_err_d = fetch_err_q || is_misaligned(redirect_pc);
    end else if (push) begin
      pc_d = pc_q + PC_STEP;  // wraps modulo 2^32 silently
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      fetch_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .rst     (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (q_wdata),
    .data_o  (q_head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  assign dec.out_valid = !q_empty;
  assign dec.out_pc    = q_head.pc;
  assign dec.out_instr = q_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: one instance at RESET_PC=0, one at RESET_PC=0xFFFFFFFC.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_ready;
  logic [31:0] imem_a0, imem_rd0, imem_a1, imem_rd1;
  logic        err0, err1;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  fetch_unit_if dec0 ();
  fetch_unit_if dec1 ();
  assign dec0.out_ready = out_ready;
  assign dec1.out_ready = out_ready;

  // Combinational imem model: three programmed words, otherwise 0x13 ^ address.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500113;
      32'h4:   return 32'h00C00193;
      32'h8:   return 32'hFF718393;
      default: return 32'h00000013 ^ a;
    endcase
  endfunction

  assign imem_rd0 = imem_word(imem_a0);
  assign imem_rd1 = imem_word(imem_a1);

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut0 (
    .clk(clk), .reset(reset), .imem_a(imem_a0), .imem_rd(imem_rd0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec(dec0.master), .fetch_err(err0)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .QDEPTH(2)) dut1 (
    .clk(clk), .reset(reset), .imem_a(imem_a1), .imem_rd(imem_rd1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec(dec1.master), .fetch_err(err1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released just after an edge; the next tick() is the first fetch edge.
  task automatic do_reset(input logic ready);
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = ready;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    tick(); tick();
    n_tests++; if (dec0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dec0.out_valid); end
    n_tests++; if (dec0.out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 00000000", dec0.out_pc); end
    n_tests++; if (dec0.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 00000000", dec0.out_instr); end
    n_tests++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err0); end
    n_tests++; if (imem_a0 !== 32'h0) begin n_fail++; $display("FAIL reset_imem_a0: got %h expected 00000000", imem_a0); end
    n_tests++; if (imem_a1 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL reset_imem_a1: got %h expected fffffffc", imem_a1); end
    reset = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    exp_pc = '{32'h0, 32'h4, 32'h8};
    exp_in = '{32'h00500113, 32'h00C00193, 32'hFF718393};
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (dec0.out_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b expected 1", i, dec0.out_valid); end
      n_tests++; if (dec0.out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h expected %h", i, dec0.out_pc, exp_pc[i]); end
      n_tests++; if (dec0.out_instr !== exp_in[i]) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h expected %h", i, dec0.out_instr, exp_in[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_pc [3];
    exp_pc = '{32'h4, 32'h8, 32'hC};
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++; if (dec0.out_valid !== 1'b1 || dec0.out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_hold_head[%0d]: got valid=%b pc=%h expected valid=1 pc=00000000", i, dec0.out_valid, dec0.out_pc); end
      if (i >= 1) begin
        n_tests++; if (imem_a0 !== 32'h8) begin n_fail++; $display("FAIL bp_imem_a[%0d]: got %h expected 00000008", i, imem_a0); end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (dec0.out_valid !== 1'b1 || dec0.out_pc !== exp_pc[i]) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, dec0.out_valid, dec0.out_pc, exp_pc[i]); end
    end
    n_tests++; if (dec0.out_instr !== 32'h0000001F) begin n_fail++; $display("FAIL bp_drain_instr: got %h expected 0000001f", dec0.out_instr); end
  endtask

  task automatic test_redirect_full();
    do_reset(1'b0);
    tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (dec0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rfull_flush: got valid=%b expected 0", dec0.out_valid); end
    n_tests++; if (imem_a0 !== 32'h40) begin n_fail++; $display("FAIL rfull_imem_a: got %h expected 00000040", imem_a0); end
    tick();
    n_tests++; if (dec0.out_valid !== 1'b1 || dec0.out_pc !== 32'h40) begin n_fail++; $display("FAIL rfull_target: got valid=%b pc=%h expected valid=1 pc=00000040", dec0.out_valid, dec0.out_pc); end
    n_tests++; if (dec0.out_instr !== 32'h00000053) begin n_fail++; $display("FAIL rfull_instr: got %h expected 00000053", dec0.out_instr); end
  endtask

  task automatic test_redirect_pop();
    do_reset(1'b0);
    tick(); tick();
    out_ready = 1'b1;
    tick();
    n_tests++; if (dec0.out_pc !== 32'h4) begin n_fail++; $display("FAIL rpop_head: got %h expected 00000004", dec0.out_pc); end
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    n_tests++; if (dec0.out_valid !== 1'b0 || imem_a0 !== 32'h80) begin n_fail++; $display("FAIL rpop_flush: got valid=%b imem_a=%h expected valid=0 imem_a=00000080", dec0.out_valid, imem_a0); end
    tick();
    n_tests++; if (dec0.out_valid !== 1'b1 || dec0.out_pc !== 32'h80) begin n_fail++; $display("FAIL rpop_target: got valid=%b pc=%h expected valid=1 pc=00000080", dec0.out_valid, dec0.out_pc); end
    tick();
    n_tests++; if (dec0.out_pc !== 32'h84 || dec0.out_instr !== 32'h00000097) begin n_fail++; $display("FAIL rpop_next: got pc=%h instr=%h expected pc=00000084 instr=00000097", dec0.out_pc, dec0.out_instr); end
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    n_tests++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL mis_err_set: got %b expected 1", err0); end
    n_tests++; if (imem_a0 !== 32'h42) begin n_fail++; $display("FAIL mis_imem_a: got %h expected 00000042", imem_a0); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_tests++; if (dec0.out_valid !== 1'b0 || err0 !== 1'b1) begin n_fail++; $display("FAIL mis_inhibit[%0d]: got valid=%b err=%b expected valid=0 err=1", i, dec0.out_valid, err0); end
    end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (err0 !== 1'b0 || imem_a0 !== 32'h0) begin n_fail++; $display("FAIL mis_reset_clear: got err=%b imem_a=%h expected err=0 imem_a=00000000", err0, imem_a0); end
    tick();
    reset = 1'b0;
    tick();
    n_tests++; if (dec0.out_valid !== 1'b1 || dec0.out_pc !== 32'h0) begin n_fail++; $display("FAIL mis_resume: got valid=%b pc=%h expected valid=1 pc=00000000", dec0.out_valid, dec0.out_pc); end
  endtask

  task automatic test_wrap_async_reset();
    do_reset(1'b1);
    tick();
    n_tests++; if (dec1.out_pc !== 32'hFFFFFFFC || dec1.out_instr !== 32'hFFFFFFEF) begin n_fail++; $display("FAIL wrap_first: got pc=%h instr=%h expected pc=fffffffc instr=ffffffef", dec1.out_pc, dec1.out_instr); end
    tick();
    n_tests++; if (dec1.out_valid !== 1'b1 || dec1.out_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_second: got valid=%b pc=%h expected valid=1 pc=00000000", dec1.out_valid, dec1.out_pc); end
    n_tests++; if (dec1.out_instr !== 32'h00500113) begin n_fail++; $display("FAIL wrap_instr: got %h expected 00500113", dec1.out_instr); end
    #2 reset = 1'b1;
    #1;
    n_tests++; if (dec1.out_valid !== 1'b0 || imem_a1 !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL async_reset: got valid=%b imem_a=%h expected valid=0 imem_a=fffffffc", dec1.out_valid, imem_a1); end
    n_tests++; if (dec1.out_pc !== 32'h0 || dec1.out_instr !== 32'h0) begin n_fail++; $display("FAIL async_reset_out: got pc=%h instr=%h expected 00000000 00000000", dec1.out_pc, dec1.out_instr); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_full();
    test_redirect_pop();
    test_misaligned();
    test_wrap_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
